// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared types and round-robin pick helper for ram_sp_arb
package ram_arb_pkg;

  localparam int MAX_REQ       = 32;
  localparam int IDX_BITS      = 5;
  localparam int DEF_ADDR_BITS = 10;
  localparam int DEF_DATA_BITS = 64;

  typedef struct packed {
    logic [DEF_DATA_BITS/8-1:0] we;
    logic [DEF_ADDR_BITS-1:0]   addr;
    logic [DEF_DATA_BITS-1:0]   wdata;
  } ram_req_t;

  typedef struct packed {
    logic                found;
    logic [IDX_BITS-1:0] idx;
  } rr_pick_t;

  // First valid requester at or after ptr, wrapping at num with an explicit compare
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input logic [IDX_BITS-1:0] ptr,
                                       input int                  num);
    rr_pick_t r;
    int       idx;
    r = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (i < num && !r.found) begin
        idx = int'(ptr) + i;
        if (idx >= num) idx = idx - num;
        if (valid[idx]) begin
          r.found = 1'b1;
          r.idx   = IDX_BITS'(idx);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ram_sp_nc.sv
// rtl/ram_sp_nc.sv - single-port byte-enable RAM, read-first, registered read, reset-cleared
module ram_sp_nc #(
  parameter int ADDR_BITS = 10,
  parameter int DATA_BITS = 64
) (
  input  logic                   clk,
  input  logic                   rstn_i,
  input  logic                   a_en,
  input  logic [DATA_BITS/8-1:0] a_we,
  input  logic [ADDR_BITS-1:0]   a_addr,
  input  logic [DATA_BITS-1:0]   a_data_in,
  output logic [DATA_BITS-1:0]   a_data_out
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam int WB    = DATA_BITS / 8;

  logic [DATA_BITS-1:0] mem [DEPTH];

  // Read-first access: output takes the old word, enabled bytes are then overwritten
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      a_data_out <= '0;
    end else if (a_en) begin
      a_data_out <= mem[a_addr];
      for (int b = 0; b < WB; b++) begin
        if (a_we[b]) mem[a_addr][b*8 +: 8] <= a_data_in[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/ram_sp_arb.sv
// rtl/ram_sp_arb.sv - round-robin arbiter sharing one single-port RAM between requesters
module ram_sp_arb
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_BITS = 10,
  parameter int DATA_BITS = 64
) (
  input  logic                             clk,
  input  logic                             rstn_i,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  output logic [NUM_REQ-1:0]               req_ready_o,
  input  logic [NUM_REQ*DATA_BITS/8-1:0]   req_we_i,
  input  logic [NUM_REQ*ADDR_BITS-1:0]     req_addr_i,
  input  logic [NUM_REQ*DATA_BITS-1:0]     req_wdata_i,
  output logic [NUM_REQ-1:0]               rsp_valid_o,
  output logic [DATA_BITS-1:0]             rsp_data_o,
  output logic [NUM_REQ-1:0]               wr_ack_o
);

  localparam int WB        = DATA_BITS / 8;
  localparam int PTR_BITS  = $clog2(NUM_REQ);

  typedef struct packed {
    logic [WB-1:0]        we;
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] wdata;
  } req_t;

  logic [PTR_BITS-1:0]  rr_ptr;
  rr_pick_t             pick;
  logic                 grant_ok;
  logic [PTR_BITS-1:0]  gidx;
  req_t                 sel;

  logic                 pend_rd;
  logic                 pend_wr;
  logic [PTR_BITS-1:0]  tag;
  logic [DATA_BITS-1:0] rd_hold;

  logic                 a_en;
  logic [WB-1:0]        a_we;
  logic [DATA_BITS-1:0] ram_q;

  // Arbitration and request mux; nothing is granted while reset is held
  always_comb begin
    pick        = rr_pick(MAX_REQ'(req_valid_i), IDX_BITS'(rr_ptr), NUM_REQ);
    grant_ok    = pick.found & rstn_i;
    gidx        = PTR_BITS'(pick.idx);
    req_ready_o = '0;
    if (grant_ok) req_ready_o[gidx] = 1'b1;
    sel.we      = req_we_i[gidx*WB +: WB];
    sel.addr    = req_addr_i[gidx*ADDR_BITS +: ADDR_BITS];
    sel.wdata   = req_wdata_i[gidx*DATA_BITS +: DATA_BITS];
    a_en        = grant_ok;
    a_we        = grant_ok ? sel.we : '0;
  end

  // Pointer advance and one-deep tag/kind pipeline for the access in flight
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      rr_ptr  <= '0;
      pend_rd <= 1'b0;
      pend_wr <= 1'b0;
      tag     <= '0;
    end else begin
      pend_rd <= grant_ok && (sel.we == '0);
      pend_wr <= grant_ok && (sel.we != '0);
      if (grant_ok) begin
        tag    <= gidx;
        rr_ptr <= (gidx == PTR_BITS'(NUM_REQ - 1)) ? '0 : gidx + PTR_BITS'(1);
      end
    end
  end

  // Keep the last read word so the shared data bus is stable between responses
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) rd_hold <= '0;
    else if (pend_rd) rd_hold <= ram_q;
  end

  // Response demux back to the issuing requester
  always_comb begin
    rsp_valid_o = '0;
    wr_ack_o    = '0;
    if (pend_rd) rsp_valid_o[tag] = 1'b1;
    if (pend_wr) wr_ack_o[tag]    = 1'b1;
    rsp_data_o  = pend_rd ? ram_q : rd_hold;
  end

  ram_sp_nc #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_BITS (DATA_BITS)
  ) u_ram (
    .clk        (clk),
    .rstn_i     (rstn_i),
    .a_en       (a_en),
    .a_we       (a_we),
    .a_addr     (sel.addr),
    .a_data_in  (sel.wdata),
    .a_data_out (ram_q)
  );

endmodule

// File: tb/tb_ram_sp_arb.sv
// tb/tb_ram_sp_arb.sv - self-checking bench for ram_sp_arb with a behavioural RAM/arbiter model
module tb_ram_sp_arb;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]   v2;
  logic [1:0]   ready2;
  logic [15:0]  we2;
  logic [19:0]  addr2;
  logic [127:0] wdata2;
  logic [1:0]   rv2;
  logic [63:0]  rdata2;
  logic [1:0]   ack2;

  logic [2:0]   v3;
  logic [2:0]   ready3;
  logic [23:0]  we3;
  logic [11:0]  addr3;
  logic [191:0] wdata3;
  logic [2:0]   rv3;
  logic [63:0]  rdata3;
  logic [2:0]   ack3;

  ram_sp_arb #(.NUM_REQ(2), .ADDR_BITS(10), .DATA_BITS(64)) dut2 (
    .clk(clk), .rstn_i(rstn), .req_valid_i(v2), .req_ready_o(ready2),
    .req_we_i(we2), .req_addr_i(addr2), .req_wdata_i(wdata2),
    .rsp_valid_o(rv2), .rsp_data_o(rdata2), .wr_ack_o(ack2));

  ram_sp_arb #(.NUM_REQ(3), .ADDR_BITS(4), .DATA_BITS(64)) dut3 (
    .clk(clk), .rstn_i(rstn), .req_valid_i(v3), .req_ready_o(ready3),
    .req_we_i(we3), .req_addr_i(addr3), .req_wdata_i(wdata3),
    .rsp_valid_o(rv3), .rsp_data_o(rdata3), .wr_ack_o(ack3));

  int errors = 0;
  int checks = 0;

  // reference model state for the 2-requester instance
  logic [63:0] mem_m [1024];
  int          m_ptr;
  logic [1:0]  exp_rv;
  logic [1:0]  exp_ack;
  logic [63:0] exp_data;
  int          last_g;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // round-robin rule: first valid index at or after ptr, modulo n
  function automatic int pick(input logic [2:0] v, input int ptr, input int n);
    for (int i = 0; i < n; i++) begin
      if (v[(ptr + i) % n]) return (ptr + i) % n;
    end
    return -1;
  endfunction

  task automatic set2(input int r, input logic v, input logic [7:0] we,
                      input logic [9:0] a, input logic [63:0] d);
    v2[r]              = v;
    we2[r*8 +: 8]      = we;
    addr2[r*10 +: 10]  = a;
    wdata2[r*64 +: 64] = d;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 1024; i++) mem_m[i] = '0;
    m_ptr = 0; exp_rv = '0; exp_ack = '0; exp_data = '0; last_g = -1;
  endtask

  // one clock of the 2-requester instance: check grant and previous-cycle responses, advance model
  task automatic step();
    int g;
    logic [7:0] we;
    logic [9:0] a;
    logic [63:0] d;
    @(negedge clk);
    g = pick({1'b0, v2}, m_ptr, 2);
    chk("ready", ready2, (g < 0) ? 2'b00 : (2'b01 << g));
    chk("rsp_valid", rv2, exp_rv);
    chk("wr_ack", ack2, exp_ack);
    chk("rsp_data", rdata2, exp_data);
    exp_rv = '0; exp_ack = '0; last_g = g;
    if (g >= 0) begin
      we = we2[g*8 +: 8]; a = addr2[g*10 +: 10]; d = wdata2[g*64 +: 64];
      if (we == 8'h00) begin
        exp_rv   = 2'b01 << g;
        exp_data = mem_m[a];
      end else begin
        for (int b = 0; b < 8; b++) if (we[b]) mem_m[a][b*8 +: 8] = d[b*8 +: 8];
        exp_ack = 2'b01 << g;
      end
      m_ptr = (g + 1) % 2;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    v2 = 2'b11; v3 = 3'b111;
    #1;
    chk("rst_ready2", ready2, 2'b00);
    chk("rst_rv2", rv2, 2'b00);
    chk("rst_ack2", ack2, 2'b00);
    chk("rst_data2", rdata2, 64'h0);
    chk("rst_ready3", ready3, 3'b000);
    v2 = '0; v3 = '0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int p3, g3, prev3;
    v2 = '0; we2 = '0; addr2 = '0; wdata2 = '0;
    v3 = '0; we3 = '0; addr3 = '0; wdata3 = '0;

    // three requesters, pattern 101 held: grants 0,2,0,2; requester 1 never chosen
    do_reset();
    v3 = 3'b101;
    p3 = 0; prev3 = -1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      g3 = pick(v3, p3, 3);
      chk("ready3", ready3, 3'b001 << g3);
      chk("ready3_idle1", ready3[1], 1'b0);
      chk("rv3", rv3, (prev3 < 0) ? 3'b000 : (3'b001 << prev3));
      prev3 = g3;
      p3 = (g3 + 1) % 3;
      @(posedge clk); #1;
    end
    v3 = '0;

    // reset then single read of addr 5
    do_reset();
    step();
    set2(0, 1, 8'h00, 10'd5, 64'h0);
    step();
    set2(0, 0, 8'h00, 10'd0, 64'h0);
    chk("single_read_rv", rv2, 2'b01);
    chk("single_read_data", rdata2, 64'h0);
    step();

    // byte-enable write then read back
    set2(1, 1, 8'hFF, 10'd3, 64'h1122334455667788);
    step();
    set2(1, 0, 8'h00, 10'd0, 64'h0);
    chk("full_wr_ack", ack2, 2'b10);
    step();
    set2(1, 1, 8'h01, 10'd3, 64'h00000000000000AA);
    step();
    set2(1, 0, 8'h00, 10'd0, 64'h0);
    chk("byte_wr_ack", ack2, 2'b10);
    set2(0, 1, 8'h00, 10'd3, 64'h0);
    step();
    set2(0, 0, 8'h00, 10'd0, 64'h0);
    chk("byte_merge", rdata2, 64'h11223344556677AA);
    step();

    // write then read of same address on consecutive cycles
    set2(0, 1, 8'hFF, 10'd7, 64'hDEAD);
    step();
    set2(0, 0, 8'h00, 10'd0, 64'h0);
    set2(1, 1, 8'h00, 10'd7, 64'h0);
    step();
    set2(1, 0, 8'h00, 10'd0, 64'h0);
    chk("wr_rd_rv", rv2, 2'b10);
    chk("wr_rd_data", rdata2, 64'hDEAD);
    step();

    // contention from reset: grants alternate 0,1,0,1
    do_reset();
    set2(0, 1, 8'h00, 10'd1, 64'h0);
    set2(1, 1, 8'h00, 10'd2, 64'h0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("alt_grant", ready2, (k % 2 == 0) ? 2'b01 : 2'b10);
      @(posedge clk); #1;
    end
    set2(0, 0, 8'h00, 10'd0, 64'h0);
    set2(1, 0, 8'h00, 10'd0, 64'h0);
    do_reset();

    // reset in the cycle after a read grant: response vanishes, RAM cleared
    set2(0, 1, 8'hFF, 10'd9, 64'h55AA);
    step();
    set2(0, 1, 8'h00, 10'd9, 64'h0);
    step();
    set2(0, 0, 8'h00, 10'd0, 64'h0);
    do_reset();
    step();
    set2(1, 1, 8'h00, 10'd9, 64'h0);
    step();
    set2(1, 0, 8'h00, 10'd0, 64'h0);
    chk("post_rst_rv", rv2, 2'b10);
    chk("post_rst_data", rdata2, 64'h0);
    step();

    // randomized traffic; an ungranted request is usually held unchanged
    for (int c = 0; c < 300; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (!(v2[r] && last_g != r && $urandom_range(3) != 0)) begin
          set2(r, 1'($urandom_range(1)),
               ($urandom_range(1) == 0) ? 8'h00 : 8'($urandom),
               10'($urandom_range(15)),
               {32'($urandom), 32'($urandom)});
        end
      end
      step();
    end
    set2(0, 0, 8'h00, 10'd0, 64'h0);
    set2(1, 0, 8'h00, 10'd0, 64'h0);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
